// File: rtl/nibble_serial_subtractor_pkg.sv
// rtl/nibble_serial_subtractor_pkg.sv - shared state encoding and nibble width
package nibble_serial_subtractor_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_subtractor_cla4_sub.sv
// rtl/nibble_serial_subtractor_cla4_sub.sv - combinational 4-bit CLA slice computing x + ~y + cin
module cla4_sub
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [3:0] yn;
    logic [3:0] p;
    logic [3:0] g;
    logic       c1;
    logic       c2;
    logic       c3;

    assign yn = ~y;
    assign p  = x ^ yn;
    assign g  = x & yn;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - nibble-serial a - b - bin with valid/ready on both sides
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t                state;
    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic                  carry;
    logic [CW-1:0]         k;
    logic [NIBBLE_W-1:0]   x_nib;
    logic [NIBBLE_W-1:0]   y_nib;
    logic [NIBBLE_W-1:0]   s_nib;
    logic                  cout;
    logic                  last;

    assign x_nib = a_r[NIBBLE_W*k +: NIBBLE_W];
    assign y_nib = b_r[NIBBLE_W*k +: NIBBLE_W];
    assign last  = (k == CW'(NIB - 1));

    // Gated by rst_n so the block never advertises readiness while held in reset.
    assign in_ready = rst_n && (state == ST_IDLE);

    cla4_sub u_slice (
        .x    (x_nib),
        .y    (y_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            k         <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r   <= a;
                        b_r   <= b;
                        carry <= ~bin;
                        k     <= '0;
                        state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    diff[NIBBLE_W*k +: NIBBLE_W] <= s_nib;
                    carry <= cout;
                    if (last) begin
                        // A carry out of a + ~b + ~bin means no borrow was needed.
                        bout      <= ~cout;
                        ovf       <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (s_nib[NIBBLE_W-1] != a_r[WIDTH-1]);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - directed bench with arithmetic reference model
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int vectors = 0;
    int miscompares = 0;
    logic [17:0] exp_q[$];

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf)
    );

    // Returns {bout, ovf, diff} from integer arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
        int ud;
        int sd;
        logic [15:0] d;
        ud = int'(ma) - int'(mb) - int'(mbin);
        sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        d  = ud[15:0];
        return {ud < 0, (sd > 32767) || (sd < -32768), d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                check("result", {14'd0, bout, ovf, diff}, {14'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        a = va; b = vb; bin = vbin; in_valid = 1'b1;
        exp_q.push_back(model(va, vb, vbin));
        step();
        in_valid = 1'b0;
        a = ~va; b = ~vb; bin = ~vbin;
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 30) begin step(); lat++; end
        if (!out_valid) check("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin);
        int lat;
        start_op(va, vb, vbin);
        step();
        wait_result(lat);
        check("latency", 32'(lat), 32'd4);
        step();
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; bin = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_outputs", {13'd0, out_valid, bout, ovf, diff}, 32'd0);

        check("model_1", 32'(model(16'h1234, 16'h0234, 1'b0)), {14'd0, 2'b00, 16'h1000});
        check("model_2", 32'(model(16'h0000, 16'h0001, 1'b0)), {14'd0, 2'b10, 16'hFFFF});
        check("model_3", 32'(model(16'h8000, 16'h0001, 1'b0)), {14'd0, 2'b01, 16'h7FFF});
        check("model_4", 32'(model(16'h7FFF, 16'hFFFF, 1'b0)), {14'd0, 2'b11, 16'h8000});
        check("model_5", 32'(model(16'h0005, 16'h0005, 1'b1)), {14'd0, 2'b10, 16'hFFFF});
        check("model_6", 32'(model(16'h0005, 16'h0005, 1'b0)), {14'd0, 2'b00, 16'h0000});
        check("model_7", 32'(model(16'h00FF, 16'h000F, 1'b0)), {14'd0, 2'b00, 16'h00F0});

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        step();

        run_op(16'h1234, 16'h0234, 1'b0);
        run_op(16'h0000, 16'h0001, 1'b0);
        run_op(16'h8000, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'hFFFF, 1'b0);
        run_op(16'h0005, 16'h0005, 1'b1);
        run_op(16'h0005, 16'h0005, 1'b0);
        run_op(16'hA5C3, 16'h5A3C, 1'b1);

        // Backpressure: hold the result while stray in_valid pulses arrive.
        begin
            int lat;
            out_ready = 1'b0;
            start_op(16'h4321, 16'h1234, 1'b1);
            step();
            wait_result(lat);
            check("bp_latency", 32'(lat), 32'd4);
            for (int i = 0; i < 6; i++) begin
                in_valid = i[0];
                a = 16'hFFFF; b = 16'h0001;
                step();
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_diff", 32'(diff), 32'h30EC);
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
            step();
            check("bp_release_in_ready", 32'(in_ready), 32'd1);
            check("bp_release_out_valid", 32'(out_valid), 32'd0);
            step();
            step();
            check("bp_no_queued_op", 32'(out_valid), 32'd0);
            check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Reset after two nibbles have been processed.
        start_op(16'hFFFF, 16'h1111, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_outputs", {13'd0, out_valid, bout, ovf, diff}, 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        check("midrst_idle", 32'(in_ready), 32'd1);
        run_op(16'h00FF, 16'h000F, 1'b0);
        check("final_diff", 32'(diff), 32'h00F0);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
